wb_skid_buffer: RTL and testbench



---
 rtl/wb_skid_buffer_pkg.sv | 16 +
 rtl/wb_skid_buffer_if.sv | 37 +++
 rtl/wb_skid_buffer_sat_counter.sv | 21 ++
 rtl/wb_skid_buffer.sv | 114 +++++++++++
 tb/tb_wb_skid_buffer.sv | 206 ++++++++++++++++++++
 5 files changed

// File: rtl/wb_skid_buffer_pkg.sv
// Shared definitions for the write-back skid buffer.
// - state_t: occupancy of the two-entry buffer (EMPTY / ONE / FULL).
// - DEF_*:   default widths (data, register address, stall counter).
package wb_skid_buffer_pkg;

  typedef enum logic [1:0] {
    EMPTY = 2'b00,
    ONE   = 2'b01,
    FULL  = 2'b10
  } state_t;

  localparam int DEF_N  = 32;
  localparam int DEF_AW = 5;
  localparam int DEF_CW = 8;

endpackage

// File: rtl/wb_skid_buffer_if.sv
// Bus bundle between the write-back mux stage, the skid buffer and the
// register-file write port.
// Upstream:   i_valid, o_ready, i_data, i_addr, i_flush
// Downstream: o_valid, i_ready, o_data, o_addr
// Debug:      o_stall_cnt (stalled-cycle count), dbg_state (buffer occupancy)
// slave  = the buffer itself; master = whoever drives and observes it.
interface wb_skid_buffer_if
  import wb_skid_buffer_pkg::*;
#(
  parameter int n  = DEF_N,
  parameter int AW = DEF_AW,
  parameter int CW = DEF_CW
) ();

  logic          i_valid;
  logic          o_ready;
  logic [n-1:0]  i_data;
  logic [AW-1:0] i_addr;
  logic          i_flush;
  logic          o_valid;
  logic          i_ready;
  logic [n-1:0]  o_data;
  logic [AW-1:0] o_addr;
  logic [CW-1:0] o_stall_cnt;
  logic [1:0]    dbg_state;

  modport slave (
    input  i_valid, i_data, i_addr, i_flush, i_ready,
    output o_ready, o_valid, o_data, o_addr, o_stall_cnt, dbg_state
  );

  modport master (
    output i_valid, i_data, i_addr, i_flush, i_ready,
    input  o_ready, o_valid, o_data, o_addr, o_stall_cnt, dbg_state
  );

endinterface

// File: rtl/wb_skid_buffer_sat_counter.sv
// Saturating up-counter with enable.
// Ports: i_clk, i_rst_n (async active-low), i_en (count this cycle),
//        o_cnt (current value, sticks at all-ones).
module sat_counter #(
  parameter int CW = 8
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  input  logic          i_en,
  output logic [CW-1:0] o_cnt
);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_cnt <= '0;
    end else if (i_en && (o_cnt != {CW{1'b1}})) begin
      o_cnt <= o_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/wb_skid_buffer.sv
// Two-entry valid/ready skid buffer between the write-back data mux and the
// register-file write port. The main entry drives o_data/o_addr directly; the
// skid entry catches the one word that arrives while the register file stalls.
// Ports: i_clk, i_rst_n (async active-low), bus (wb_skid_buffer_if.slave).
//
// Handshake: a word moves upstream->buffer when i_valid & o_ready (accept) and
// buffer->register file when o_valid & i_ready (issue), both sampled on the
// rising edge. o_ready and o_valid decode only the state flop, so neither has a
// combinational path from i_valid, i_ready or i_flush.
module wb_skid_buffer
  import wb_skid_buffer_pkg::*;
#(
  parameter int n  = DEF_N,
  parameter int AW = DEF_AW,
  parameter int CW = DEF_CW
) (
  input  logic           i_clk,
  input  logic           i_rst_n,
  wb_skid_buffer_if.slave bus
);

  state_t        state_q, state_d;
  logic [n-1:0]  main_data_q, skid_data_q;
  logic [AW-1:0] main_addr_q, skid_addr_q;
  logic          accept, issue;
  logic          load_main_in, load_main_skid, load_skid;

  assign bus.o_valid   = (state_q != EMPTY);
  assign bus.o_ready   = (state_q != FULL);
  assign bus.o_data    = main_data_q;
  assign bus.o_addr    = main_addr_q;
  assign bus.dbg_state = state_q;

  assign accept = bus.i_valid & bus.o_ready;
  assign issue  = bus.o_valid & bus.i_ready;

  always_comb begin
    state_d        = state_q;
    load_main_in   = 1'b0;
    load_main_skid = 1'b0;
    load_skid      = 1'b0;
    case (state_q)
      EMPTY: begin
        if (accept) begin
          state_d      = ONE;
          load_main_in = 1'b1;
        end
      end
      ONE: begin
        if (accept && issue) begin
          load_main_in = 1'b1;
        end else if (accept) begin
          state_d   = FULL;
          load_skid = 1'b1;
        end else if (issue) begin
          state_d = EMPTY;
        end
      end
      FULL: begin
        // o_ready is low here, so only the drain case exists.
        if (issue) begin
          state_d        = ONE;
          load_main_skid = 1'b1;
        end
      end
      default: state_d = EMPTY;
    endcase
    // Flush drops the valid bits only; data registers keep their last value
    // and a same-cycle accept is thrown away.
    if (bus.i_flush) begin
      state_d        = EMPTY;
      load_main_in   = 1'b0;
      load_main_skid = 1'b0;
      load_skid      = 1'b0;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= EMPTY;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      main_data_q <= '0;
      main_addr_q <= '0;
      skid_data_q <= '0;
      skid_addr_q <= '0;
    end else begin
      if (load_main_in) begin
        main_data_q <= bus.i_data;
        main_addr_q <= bus.i_addr;
      end else if (load_main_skid) begin
        main_data_q <= skid_data_q;
        main_addr_q <= skid_addr_q;
      end
      if (load_skid) begin
        skid_data_q <= bus.i_data;
        skid_addr_q <= bus.i_addr;
      end
    end
  end

  sat_counter #(.CW(CW)) u_stall_cnt (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_en    (bus.o_valid & ~bus.i_ready),
    .o_cnt   (bus.o_stall_cnt)
  );

endmodule

// File: tb/tb_wb_skid_buffer.sv
// Bench for wb_skid_buffer: two instances share one stimulus stream, one with
// the default 8-bit stall counter and one with a 3-bit counter. A queue model
// of the buffer (at most two words, FIFO) predicts outputs every cycle.
module tb_wb_skid_buffer;
  localparam int N  = 32;
  localparam int AW = 5;

  // ---------------- clock / reset ----------------
  logic i_clk = 1'b0;
  logic i_rst_n = 1'b0;
  always #5 i_clk = ~i_clk;

  // ---------------- shared stimulus ----------------
  logic          in_valid = 1'b0;
  logic [N-1:0]  in_data  = '0;
  logic [AW-1:0] in_addr  = '0;
  logic          in_ready = 1'b0;
  logic          in_flush = 1'b0;

  wb_skid_buffer_if #(.n(N), .AW(AW), .CW(8)) bus8 ();
  wb_skid_buffer_if #(.n(N), .AW(AW), .CW(3)) bus3 ();

  assign bus8.i_valid = in_valid;
  assign bus8.i_data  = in_data;
  assign bus8.i_addr  = in_addr;
  assign bus8.i_ready = in_ready;
  assign bus8.i_flush = in_flush;
  assign bus3.i_valid = in_valid;
  assign bus3.i_data  = in_data;
  assign bus3.i_addr  = in_addr;
  assign bus3.i_ready = in_ready;
  assign bus3.i_flush = in_flush;

  wb_skid_buffer #(.n(N), .AW(AW), .CW(8)) dut8 (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .bus     (bus8)
  );

  wb_skid_buffer #(.n(N), .AW(AW), .CW(3)) dut3 (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .bus     (bus3)
  );

  // ---------------- scoreboard ----------------
  int errors = 0;
  int checks = 0;
  logic cmp_en = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: words waiting in the buffer, oldest first.
  logic [N+AW-1:0] exp_q[$];
  logic [N+AW-1:0] last_front = '0;
  int exp_cnt8 = 0;
  int exp_cnt3 = 0;
  int m_sz;
  logic m_acc, m_iss;

  always @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      exp_q.delete();
      last_front = '0;
      exp_cnt8 = 0;
      exp_cnt3 = 0;
    end else begin
      m_sz  = exp_q.size();
      m_acc = in_valid && (m_sz < 2);
      m_iss = (m_sz > 0) && in_ready;
      if ((m_sz > 0) && !in_ready) begin
        if (exp_cnt8 < 255) exp_cnt8++;
        if (exp_cnt3 < 7) exp_cnt3++;
      end
      if (in_flush) begin
        exp_q.delete();
      end else begin
        if (m_iss) void'(exp_q.pop_front());
        if (m_acc) exp_q.push_back({in_addr, in_data});
      end
      if (exp_q.size() > 0) last_front = exp_q[0];
    end
  end

  // Per-cycle compare against the model, away from the rising edge.
  always @(negedge i_clk) begin
    if (i_rst_n && cmp_en) begin
      chk("o_valid8", 64'(bus8.o_valid), 64'(exp_q.size() > 0));
      chk("o_ready8", 64'(bus8.o_ready), 64'(exp_q.size() < 2));
      chk("o_data8",  64'(bus8.o_data),  64'(last_front[N-1:0]));
      chk("o_addr8",  64'(bus8.o_addr),  64'(last_front[N+AW-1:N]));
      chk("stall8",   64'(bus8.o_stall_cnt), 64'(exp_cnt8));
      chk("o_valid3", 64'(bus3.o_valid), 64'(exp_q.size() > 0));
      chk("o_data3",  64'(bus3.o_data),  64'(last_front[N-1:0]));
      chk("stall3",   64'(bus3.o_stall_cnt), 64'(exp_cnt3));
    end
  end

  // ---------------- driver ----------------
  // Called at negedge+1; applies inputs for the coming rising edge and
  // returns at the following negedge+1 with the results settled.
  task automatic cycle(input logic v, input logic [N-1:0] d, input logic [AW-1:0] a,
                       input logic r, input logic f);
    in_valid = v;
    in_data  = d;
    in_addr  = a;
    in_ready = r;
    in_flush = f;
    @(negedge i_clk);
    #1;
  endtask

  // ---------------- directed + random tests ----------------
  initial begin
    #1;
    chk("rst_valid", 64'(bus8.o_valid), 64'd0);
    chk("rst_ready", 64'(bus8.o_ready), 64'd1);
    chk("rst_data",  64'(bus8.o_data),  64'd0);
    chk("rst_cnt",   64'(bus8.o_stall_cnt), 64'd0);
    @(negedge i_clk);
    @(negedge i_clk);
    #1;
    i_rst_n = 1'b1;
    cmp_en  = 1'b1;

    // Pass-through and back-to-back stream.
    cycle(1'b1, 32'hDEADBEEF, 5'd5, 1'b1, 1'b0);
    chk("pt_valid", 64'(bus8.o_valid), 64'd1);
    chk("pt_data",  64'(bus8.o_data),  64'hDEADBEEF);
    chk("pt_addr",  64'(bus8.o_addr),  64'd5);
    for (int i = 1; i <= 3; i++) begin
      cycle(1'b1, 32'(i), 5'(i), 1'b1, 1'b0);
      chk("stream_data", 64'(bus8.o_data), 64'(i));
    end
    cycle(1'b0, 32'h0, 5'd0, 1'b1, 1'b0);
    chk("stream_done", 64'(bus8.o_valid), 64'd0);

    // Skid fill and drain.
    cycle(1'b1, 32'hAAAA0001, 5'd3, 1'b0, 1'b0);
    chk("skid_one", 64'(bus8.o_data), 64'hAAAA0001);
    cycle(1'b1, 32'hAAAA0002, 5'd4, 1'b0, 1'b0);
    chk("skid_full_rdy", 64'(bus8.o_ready), 64'd0);
    chk("skid_hold", 64'(bus8.o_data), 64'hAAAA0001);
    cycle(1'b0, 32'h0, 5'd0, 1'b0, 1'b0);
    chk("skid_cnt", 64'(bus8.o_stall_cnt), 64'd2);
    cycle(1'b0, 32'h0, 5'd0, 1'b1, 1'b0);
    chk("skid_second", 64'(bus8.o_data), 64'hAAAA0002);
    chk("skid_second_addr", 64'(bus8.o_addr), 64'd4);
    cycle(1'b0, 32'h0, 5'd0, 1'b1, 1'b0);
    chk("skid_empty", 64'(bus8.o_valid), 64'd0);

    // Flush from FULL with a colliding push.
    cycle(1'b1, 32'h11, 5'd1, 1'b0, 1'b0);
    cycle(1'b1, 32'h22, 5'd2, 1'b0, 1'b0);
    cycle(1'b1, 32'h55, 5'd7, 1'b0, 1'b1);
    chk("flush_valid", 64'(bus8.o_valid), 64'd0);
    chk("flush_ready", 64'(bus8.o_ready), 64'd1);
    chk("flush_data_kept", 64'(bus8.o_data), 64'h11);
    chk("flush_cnt", 64'(bus8.o_stall_cnt), 64'd4);
    cycle(1'b0, 32'h0, 5'd0, 1'b1, 1'b0);
    chk("flush_no_55", 64'(bus8.o_valid), 64'd0);

    // Saturation of the narrow counter under a long stall.
    cycle(1'b1, 32'h77, 5'd6, 1'b0, 1'b0);
    for (int i = 0; i < 10; i++) begin
      cycle(1'b0, 32'h0, 5'd0, 1'b0, 1'b0);
      chk("sat_data_hold", 64'(bus3.o_data), 64'h77);
    end
    chk("sat_cnt3", 64'(bus3.o_stall_cnt), 64'd7);
    chk("sat_cnt8", 64'(bus8.o_stall_cnt), 64'd14);
    cycle(1'b0, 32'h0, 5'd0, 1'b1, 1'b0);

    // Asynchronous reset with both entries held.
    cycle(1'b1, 32'h1234, 5'd9, 1'b0, 1'b0);
    cycle(1'b1, 32'h5678, 5'd10, 1'b0, 1'b0);
    i_rst_n = 1'b0;
    #1;
    chk("arst_valid", 64'(bus8.o_valid), 64'd0);
    chk("arst_ready", 64'(bus8.o_ready), 64'd1);
    chk("arst_cnt8",  64'(bus8.o_stall_cnt), 64'd0);
    chk("arst_cnt3",  64'(bus3.o_stall_cnt), 64'd0);
    chk("arst_data",  64'(bus8.o_data), 64'd0);
    cycle(1'b0, 32'h0, 5'd0, 1'b0, 1'b0);
    cycle(1'b0, 32'h0, 5'd0, 1'b0, 1'b0);
    i_rst_n = 1'b1;

    // Random traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      cycle(1'($urandom_range(0, 1)), $urandom, 5'($urandom_range(0, 31)),
            1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 15) == 0));
    end
    cycle(1'b0, 32'h0, 5'd0, 1'b1, 1'b0);
    cycle(1'b0, 32'h0, 5'd0, 1'b1, 1'b0);
    cmp_en = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
